spi_slave_sync: RTL and testbench
=================================

// Module: spi_slave_sync
// PURPOSE
//  System-clock-domain SPI slave: the receiving end of SPI_MASTER's LOAD/SCLK/MOSI/MISO link.
//  SCLK, LOAD and MOSI are oversampled on clk rather than used as clocks.
//  Returns one M-bit word per frame and transmits one M-bit word per frame, MSB first.
//  Sits beside user logic, which consumes DO on DO_VLD and supplies DI on DI_ACK.
// PARAMETERS
//  M      16  frame/word width in bits (same value as `m)
//  SYNC   2   synchroniser depth for sclk/load/mosi, minimum 2
// PORTS
//  clk      in   1  system clock; must run at least 4x the SCLK frequency
//  clr_n    in   1  asynchronous, active-low reset
//  sclk     in   1  SPI clock from master; idles low; sample on rise, shift on fall
//  load     in   1  frame strobe from master; low = frame active, rising edge = frame end
//  mosi     in   1  serial data from master
//  miso     out  1  serial data to master
//  di       in   M  word to transmit; sampled at frame start
//  di_ack   out  1  1-clk pulse: di captured, user may present the next word
//  do       out  M  last correctly received word; holds until the next good frame
//  do_vld   out  1  1-clk pulse: do updated
//  frm_err  out  1  1-clk pulse: frame ended with bit count != M
//  busy     out  1  high while state = SHIFT
//  sr_stx   out  M  tx shift register (debug)
//  sr_srx   out  M  rx shift register (debug)
// BEHAVIOUR
//  Reset (clr_n=0, async): all regs and outputs 0. This covers miso, do, do_vld, di_ack,
//   frm_err, busy, sr_*, bit_cnt and the synchronisers. state=IDLE.
//  Input path: sclk, load and mosi each pass through SYNC flops, then one extra flop for
//   edge detection. mosi uses the same delay, so it stays aligned with sclk.
//  Edge events are computed in the cycle after the sync output changes.
//   For SYNC=2, the response register updates on the 3rd clk rising edge after the pin change.
//  FSM states:
//   IDLE:  load_fall -> SHIFT
//          on entry: sr_stx<=di, miso<=di[M-1], bit_cnt<=0, di_ack=1 for one cycle
//          sclk edges in IDLE are ignored
//   SHIFT: sclk_rise: sr_srx<={sr_srx[M-2:0],mosi_s}; bit_cnt<=bit_cnt+1, saturating at M+1
//          sclk_fall with bit_cnt in 1..M-1: sr_stx<={sr_stx[M-2:0],1'b0}; miso<=sr_stx[M-2]
//          sclk_fall with bit_cnt>=M: miso holds
//          load_rise: if bit_cnt==M then do<=sr_srx and do_vld=1; else frm_err=1 and do holds
//          load_rise always -> IDLE
//   IDLE: miso holds its last value; busy=0
//  Simultaneous events in one cycle:
//   load edge + sclk edge: the load edge wins and the sclk edge is dropped
//   (a frame ending on load_rise with a concurrent sclk_rise does not count that bit)
//  bit_cnt width is clog2(M+2). Saturation at M+1 marks over-clocked frames as errors.
//  Reset mid-frame returns to IDLE with no do_vld or frm_err pulse.
//  A new load_fall must be >=1 clk after returning to IDLE. The master's gap guarantees this.
//  Total latency: load pin rise to do_vld is 3 clk (SYNC=2); load pin fall to di_ack is 3 clk.
// STRUCTURE
//  Shared include spi_defs.vh holds:
//   `m (=16), the state encodings (IDLE=2'd0, SHIFT=2'd1), and SPI mode constants
//   (CPOL=0, CPHA=0), so master and slave agree.
//  Sub-module spi_sync_edge (param SYNC): one input to sync output plus rise/fall pulses.
//   Instantiated for sclk and load. mosi uses a plain SYNC-deep delay chain.
//  Top level: FSM, bit counter, two shift registers, output registers.
// TESTING
//  1. Reset: clr_n=0 for 3 clk -> every output 0.
//     Release -> outputs stay 0 with load=1, sclk=0.
//  2. Full duplex, clk=8x SCLK: di=16'hA5C3; master sends 16'h3C5A.
//     -> di_ack one pulse; MISO bits match A5C3 MSB first; do=16'h3C5A; do_vld one pulse,
//        3 clk after load rises.
//  3. Short frame: 12 SCLKs then load rises -> frm_err one pulse; do keeps 16'h3C5A; no do_vld.
//  4. Long frame: 18 SCLKs -> frm_err one pulse, do unchanged.
//     The next good frame (16'h0001) -> do=16'h0001.
//  5. Back-to-back frames with a 2-clk gap: 16'hFFFF then 16'h0000 -> two do_vld pulses,
//     with do values in order.
//  6. Reset mid-frame after 7 bits -> state IDLE, outputs 0, no pulses.
//     The next 16'h1234 frame is received correctly.
//  Bench also checks: sclk toggling with load=1 leaves sr_* unchanged.

Source files
------------

// File: rtl/spi_slave_sync_pkg.sv
// Shared definitions for the system-clock-domain SPI slave.
//  - default frame width and synchroniser depth
//  - SPI mode constants (CPOL/CPHA) so master and slave agree on edges
//  - FSM state encodings, kept as plain 2-bit constants so they line up
//    with the legacy encodings used elsewhere (IDLE=0, SHIFT=1)
package spi_slave_sync_pkg;

  localparam int SPI_M    = 16;  // frame / word width in bits
  localparam int SPI_SYNC = 2;   // synchroniser depth, minimum 2

  localparam bit SPI_CPOL = 1'b0;  // SCLK idles low
  localparam bit SPI_CPHA = 1'b0;  // sample on leading edge, shift on trailing

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

endpackage

// File: rtl/spi_slave_sync_if.sv
// SPI link plus user-side word interface of spi_slave_sync.
//  SPI link : sclk, load, mosi (master -> slave), miso (slave -> master)
//  user side: di (word to send), di_ack, do_data (received word), do_vld,
//             frm_err
//  Handshake: there is no back-pressure. di must be valid whenever a frame
//  may start; di_ack is a 1-clk pulse meaning "di was captured, present the
//  next word". do_vld is a 1-clk pulse meaning "do_data was just updated";
//  the user must consume do_data before the next good frame ends. frm_err is
//  a 1-clk pulse for a frame whose bit count was not M.
//  ("do" is a language keyword, hence do_data.)
//  Modports: slave = the SPI slave itself, master = whatever drives it.
interface spi_slave_sync_if
  import spi_slave_sync_pkg::*;
#(
  parameter int M = SPI_M
) ();
  logic         sclk;
  logic         load;
  logic         mosi;
  logic         miso;
  logic [M-1:0] di;
  logic         di_ack;
  logic [M-1:0] do_data;
  logic         do_vld;
  logic         frm_err;

  modport slave (
    input  sclk, load, mosi, di,
    output miso, di_ack, do_data, do_vld, frm_err
  );

  modport master (
    output sclk, load, mosi, di,
    input  miso, di_ack, do_data, do_vld, frm_err
  );
endinterface

// File: rtl/spi_slave_sync_sync_edge.sv
// spi_sync_edge: brings one asynchronous pin into the clk domain through a
// SYNC-deep flop chain, then one more flop for edge detection.
//  clk, clr_n : system clock, async active-low reset
//  d          : asynchronous input pin
//  rise, fall : 1-clk pulses, asserted in the cycle after the synchronised
//               level changes (combinational from registers)
module spi_sync_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] chain;
  logic            prev;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC-2:0], d};
      prev  <= chain[SYNC-1];
    end
  end

  assign rise = chain[SYNC-1] & ~prev;
  assign fall = ~chain[SYNC-1] & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave that oversamples SCLK/LOAD/MOSI on clk.
// Receives and transmits one M-bit word per frame, MSB first.
//  clk, clr_n : system clock (>= 4x SCLK), async active-low reset
//  bus        : spi_slave_sync_if slave modport (SPI link + user words)
//  busy       : high while the FSM is in SHIFT
//  sr_stx     : tx shift register (debug)
//  sr_srx     : rx shift register (debug)
//  state      : FSM state (debug), ST_IDLE / ST_SHIFT
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int M    = SPI_M,
  parameter int SYNC = SPI_SYNC
) (
  input  logic                clk,
  input  logic                clr_n,
  spi_slave_sync_if.slave     bus,
  output logic                busy,
  output logic [M-1:0]        sr_stx,
  output logic [M-1:0]        sr_srx,
  output logic [1:0]          state
);

  // Counter saturates at M+1 so that over-clocked frames never wrap back
  // to M and get mistaken for good ones.
  localparam int              CW      = $clog2(M + 2);
  localparam logic [CW-1:0]   CNT_M   = CW'(M);
  localparam logic [CW-1:0]   CNT_MAX = CW'(M + 1);

  logic          sclk_rise, sclk_fall;
  logic          load_rise, load_fall;
  logic [SYNC-1:0] mosi_chain;
  logic          mosi_s;
  logic          sample_ev, shift_ev;
  logic [CW-1:0] bit_cnt;

  spi_sync_edge #(.SYNC(SYNC)) u_sclk_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (bus.sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC(SYNC)) u_load_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (bus.load),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  // mosi gets the same SYNC-deep delay as the sclk chain, so mosi_s is the
  // pin value at the moment the sclk edge was seen (the edge flop adds one
  // more cycle, but the edge event and mosi_s line up in the same cycle).
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC-2:0], bus.mosi};
    end
  end
  assign mosi_s = mosi_chain[SYNC-1];

  // Modes 0 and 3 both sample on the rising SCLK edge and shift on falling.
  assign sample_ev = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
  assign shift_ev  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      sr_stx      <= '0;
      sr_srx      <= '0;
      bus.miso    <= 1'b0;
      bus.do_data <= '0;
      bus.do_vld  <= 1'b0;
      bus.di_ack  <= 1'b0;
      bus.frm_err <= 1'b0;
    end else begin
      bus.do_vld  <= 1'b0;
      bus.di_ack  <= 1'b0;
      bus.frm_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // SCLK activity while idle is ignored; miso keeps its last bit.
          if (load_fall) begin
            state      <= ST_SHIFT;
            sr_stx     <= bus.di;
            bus.miso   <= bus.di[M-1];
            bit_cnt    <= '0;
            bus.di_ack <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // load edge has priority: a concurrent sclk edge is dropped.
          if (load_rise) begin
            if (bit_cnt == CNT_M) begin
              bus.do_data <= sr_srx;
              bus.do_vld  <= 1'b1;
            end else begin
              bus.frm_err <= 1'b1;
            end
            state <= ST_IDLE;
          end else if (sample_ev) begin
            sr_srx <= {sr_srx[M-2:0], mosi_s};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_ev && (bit_cnt != '0) && (bit_cnt < CNT_M)) begin
            // Once all M bits have gone out, miso simply holds.
            sr_stx   <= {sr_stx[M-2:0], 1'b0};
            bus.miso <= sr_stx[M-2];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_sync.sv
module tb_spi_slave_sync;
  import spi_slave_sync_pkg::*;

  localparam int M    = 16;
  localparam int HALF = 4;   // clk cycles per SCLK half period (clk = 8x SCLK)

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_sync_if #(.M(M)) bus ();
  logic         busy;
  logic [M-1:0] sr_stx;
  logic [M-1:0] sr_srx;
  logic [1:0]   state;

  spi_slave_sync #(.M(M), .SYNC(2)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .bus    (bus.slave),
    .busy   (busy),
    .sr_stx (sr_stx),
    .sr_srx (sr_srx),
    .state  (state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  logic [M-1:0] exp_q[$];
  logic [M-1:0] mon_exp;
  int vld_cnt = 0, ack_cnt = 0, err_cnt = 0;
  int vld_cyc = 0, ack_cyc = 0;
  int fall_cyc = 0, rise_cyc = 0;

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (bus.do_vld === 1'b1) begin
      vld_cnt++;
      vld_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL do_vld_unexpected: do=%0h with no word expected", bus.do_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.do_data !== mon_exp) begin
          errors++;
          $display("FAIL do_data: got %0h expected %0h", bus.do_data, mon_exp);
        end
      end
    end
    if (bus.di_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (bus.frm_err === 1'b1) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Clocks nbits SCLK periods with load already low; returns the MISO bits
  // seen just before each rising edge (first M of them, MSB first).
  task automatic shift_bits(input logic [M-1:0] tx_w, input int nbits, output logic [M-1:0] cap);
    logic [M-1:0] sh;
    sh  = tx_w;
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = sh[M-1];
      sh = sh << 1;
      tick(HALF);
      if (i < M) cap = {cap[M-2:0], bus.miso};
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
      if (i == 1) check("busy_in_frame", {15'd0, busy}, 16'd1);
    end
  endtask

  task automatic frame(input logic [M-1:0] di_w, input logic [M-1:0] tx_w, input int nbits,
                       output logic [M-1:0] cap);
    bus.di   = di_w;
    bus.load = 1'b0;
    fall_cyc = cyc;
    tick(HALF);
    shift_bits(tx_w, nbits, cap);
    tick(HALF);
    bus.load = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_miso"},    {15'd0, bus.miso},    16'd0);
    check({tag, "_do"},      bus.do_data,          16'd0);
    check({tag, "_do_vld"},  {15'd0, bus.do_vld},  16'd0);
    check({tag, "_di_ack"},  {15'd0, bus.di_ack},  16'd0);
    check({tag, "_frm_err"}, {15'd0, bus.frm_err}, 16'd0);
    check({tag, "_busy"},    {15'd0, busy},        16'd0);
    check({tag, "_sr_stx"},  sr_stx,               16'd0);
    check({tag, "_sr_srx"},  sr_srx,               16'd0);
    check({tag, "_state"},   {14'd0, state},       {14'd0, ST_IDLE});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [M-1:0] di;       // word the user offers
    logic [M-1:0] tx;       // word the master sends
    int           nbits;    // SCLK periods in the frame
    int           gap;      // clk cycles with load high after the frame
    bit           ckpt;     // check counters / do after this frame
    bit           good;     // expected: do_vld (1) or frm_err (0)
    logic [M-1:0] exp_do;   // expected do_data at the checkpoint
  } vec_t;

  vec_t tab[6];

  initial begin
    logic [M-1:0] cap, exp_cap;
    int acc_vld, acc_err, acc_ack;
    int base_vld, base_err, base_ack;

    tab[0] = '{16'hA5C3, 16'h3C5A, 16, 12, 1'b1, 1'b1, 16'h3C5A};
    tab[1] = '{16'h1111, 16'h0ABC, 12, 12, 1'b1, 1'b0, 16'h3C5A};
    tab[2] = '{16'h2222, 16'h5555, 18, 12, 1'b1, 1'b0, 16'h3C5A};
    tab[3] = '{16'h8001, 16'h0001, 16, 12, 1'b1, 1'b1, 16'h0001};
    tab[4] = '{16'h7E7E, 16'hFFFF, 16,  2, 1'b0, 1'b1, 16'hFFFF};
    tab[5] = '{16'h0F0F, 16'h0000, 16, 12, 1'b1, 1'b1, 16'h0000};

    bus.sclk = 1'b0;
    bus.load = 1'b1;
    bus.mosi = 1'b0;
    bus.di   = '0;

    // Reset: held 3 clk, then released with the link idle.
    tick(3);
    check_idle_zero("rst_held");
    clr_n = 1'b1;
    tick(6);
    check_idle_zero("rst_rel");

    // Table-driven frames.
    acc_vld = 0; acc_err = 0; acc_ack = 0;
    base_vld = vld_cnt; base_err = err_cnt; base_ack = ack_cnt;
    for (int v = 0; v < 6; v++) begin
      if (tab[v].good) exp_q.push_back(tab[v].tx);
      acc_vld += tab[v].good ? 1 : 0;
      acc_err += tab[v].good ? 0 : 1;
      acc_ack += 1;
      frame(tab[v].di, tab[v].tx, tab[v].nbits, cap);
      exp_cap = (tab[v].nbits >= M) ? tab[v].di : (tab[v].di >> (M - tab[v].nbits));
      check($sformatf("miso_f%0d", v), cap, exp_cap);
      check($sformatf("di_ack_lat_f%0d", v), 16'(ack_cyc - fall_cyc), 16'd3);
      tick(tab[v].gap);
      if (tab[v].ckpt) begin
        check($sformatf("do_vld_cnt_f%0d", v), 16'(vld_cnt - base_vld), 16'(acc_vld));
        check($sformatf("frm_err_cnt_f%0d", v), 16'(err_cnt - base_err), 16'(acc_err));
        check($sformatf("di_ack_cnt_f%0d", v), 16'(ack_cnt - base_ack), 16'(acc_ack));
        check($sformatf("do_hold_f%0d", v), bus.do_data, tab[v].exp_do);
        if (tab[v].good)
          check($sformatf("do_vld_lat_f%0d", v), 16'(vld_cyc - rise_cyc), 16'd3);
        acc_vld = 0; acc_err = 0; acc_ack = 0;
        base_vld = vld_cnt; base_err = err_cnt; base_ack = ack_cnt;
      end
    end

    // Reset in the middle of a frame after 7 bits: no pulses, all cleared.
    bus.di   = 16'h1357;
    bus.load = 1'b0;
    tick(HALF);
    shift_bits(16'hBEEF, 7, cap);
    tick(2);
    clr_n = 1'b0;
    tick(1);
    check_idle_zero("rst_mid");
    tick(2);
    bus.load = 1'b1;
    bus.sclk = 1'b0;
    tick(1);
    clr_n = 1'b1;
    tick(8);
    check("rst_mid_no_vld", 16'(vld_cnt - base_vld), 16'd0);
    check("rst_mid_no_err", 16'(err_cnt - base_err), 16'd0);

    // Next frame after the reset is received correctly.
    exp_q.push_back(16'h1234);
    frame(16'h00FF, 16'h1234, 16, cap);
    check("miso_after_rst", cap, 16'h00FF);
    tick(12);
    check("do_after_rst", bus.do_data, 16'h1234);
    check("vld_after_rst", 16'(vld_cnt - base_vld), 16'd1);
    check("sr_srx_after", sr_srx, 16'h1234);
    check("sr_stx_after", sr_stx, 16'h8000);
    base_vld = vld_cnt; base_err = err_cnt; base_ack = ack_cnt;

    // SCLK toggling with load high must not disturb anything.
    for (int i = 0; i < 6; i++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      tick(HALF);
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
    tick(8);
    check("idle_sclk_srx", sr_srx, 16'h1234);
    check("idle_sclk_stx", sr_stx, 16'h8000);
    check("idle_sclk_miso", {15'd0, bus.miso}, 16'd1);
    check("idle_sclk_busy", {15'd0, busy}, 16'd0);
    check("idle_sclk_pulses", 16'((vld_cnt - base_vld) + (err_cnt - base_err) + (ack_cnt - base_ack)), 16'd0);

    check("exp_q_empty", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
